cdc_sync_bus: RTL and testbench
===============================

# cdc_sync_bus

Parametrised multi-channel single-bit synchroniser for asynchronous level signals entering the destination clock domain. Each of WIDTH independent bits passes through a STAGES-deep flop chain. An optional per-channel stability filter follows the chain, and registered edge detection provides per-channel rise/fall pulses plus an any-change flag. It replaces ad-hoc single-bit synchronisers wherever status lines, interrupts or mode straps cross into the accelerator core clock.

## Interface
- WIDTH, 1: number of independent channels; must be ≥1.
- STAGES, 2: synchroniser flops per channel; must be ≥2.
- RST_VAL, '0 (WIDTH bits): reset value of every chain, filter and history flop, per channel.
- FILTER_CYCLES, 0: 0 disables the filter; N>0 requires N consecutive identical synchronised samples before o_signal changes.
- i_dst_clk  in  1  destination clock.
- i_dst_rstn  in  1  reset i_dst_rstn, asynchronous, active-low; clock i_dst_clk.
- i_signal  in  WIDTH  asynchronous level inputs; bits are uncorrelated and carry no bus-coherency guarantee.
- o_signal  out  WIDTH  synchronised (and filtered) level.
- o_rise  out  WIDTH  one-cycle pulse per channel on a 0→1 transition of o_signal.
- o_fall  out  WIDTH  one-cycle pulse per channel on a 1→0 transition of o_signal.
- o_change  out  1  OR-reduction of (o_rise | o_fall).

## Operation
- Chain: per channel, q[0]=i_signal; q[k]<=q[k-1] for k=1..STAGES; s=q[STAGES]. All chain flops carry the ASYNC_REG attribute and are split for lint.
- FILTER_CYCLES=0: o_signal=s; no counter logic is generated.
- FILTER_CYCLES=N>0: per channel, filtered flop f, counter c of width $clog2(N+1), o_signal=f.
  - s==f: c<=0.
  - s!=f and c==N-1: f<=s, c<=0.
  - s!=f otherwise: c<=c+1.
  - If s returns to f before acceptance, c clears. Glitches shorter than N cycles never reach o_signal.
- Edge detect: history flop p<=o_signal each cycle. o_rise=o_signal&~p, o_fall=~o_signal&p, derived from flops only.
- Channels are fully independent. Simultaneous transitions on several bits yield simultaneous pulses, and o_change is high for that single cycle.
- Reset: all q, f, p flops go to RST_VAL and c to 0. After reset, o_signal=RST_VAL and o_rise=o_fall=0, o_change=0. No spurious edge appears at reset release, even when i_signal≠RST_VAL; the real transition is reported after the normal latency.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously) and any filter count in progress is discarded.

## Timing
- Latency (input stable before edge 1 → o_signal updated after edge L): L=STAGES when FILTER_CYCLES=0, L=STAGES+FILTER_CYCLES otherwise.
- o_rise/o_fall assert in the same cycle o_signal first shows the new value, for exactly one cycle.
- Two input transitions must be separated by at least STAGES+FILTER_CYCLES+1 destination cycles to be reported as distinct edges. Closer transitions may be merged or filtered, which is by design.
- Minimum input pulse width for guaranteed capture: FILTER_CYCLES+1 destination periods (2 periods when the filter is off).
- Metastability settling is the chain's only timing requirement. The block has no combinational path from i_signal to any output.

## Test plan
- Reset value: WIDTH=4, RST_VAL=4'b1010, i_signal=4'b1010, release reset → o_signal=4'b1010 and no rise/fall/change pulse in the following 10 cycles.
- Basic latency: WIDTH=1, STAGES=3, FILTER=0, i_signal 0→1 before edge 1 → o_signal=1 after edge 3; o_rise=1 for exactly that cycle; o_change=1 in that cycle.
- Filter accept: STAGES=2, FILTER=4, hold i_signal=1 → o_signal=1 after edge 6 with a single o_rise pulse.
- Glitch reject: FILTER=4, 3-cycle high pulse on i_signal → o_signal stays 0 and no pulses. A 4-cycle pulse → o_signal goes 1 then 0, with exactly one o_rise and one o_fall.
- Multi-channel independence: WIDTH=8, bits 0 and 5 rise in the same cycle while bit 3 falls → o_rise=8'h21 and o_fall=8'h08 in the same cycle; o_change high for one cycle only.
- Mid-operation reset: FILTER=4, assert reset at count 2 of an accepting transition → outputs at RST_VAL immediately. After release with the input held, acceptance takes the full STAGES+4 cycles.

Source files
------------

// File: rtl/cdc_sync_bus.sv
// cdc_sync_bus: multi-channel single-bit level synchroniser into the i_dst_clk
// domain, with an optional per-channel stability filter and registered-source
// edge detection (rise/fall pulses plus an any-change flag).
module cdc_sync_bus #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      STAGES        = 2,
  parameter logic [WIDTH-1:0] RST_VAL       = '0,
  parameter int unsigned      FILTER_CYCLES = 0
) (
  input  logic             i_dst_clk,
  input  logic             i_dst_rstn,
  input  logic [WIDTH-1:0] i_signal,
  output logic [WIDTH-1:0] o_signal,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_change
);

  // Elaboration-time parameter sanity
  if (WIDTH < 1) begin : g_bad_width
    $error("cdc_sync_bus: WIDTH must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_bus: STAGES must be >= 2");
  end

  // Stage k holds the input delayed by k+1 destination cycles
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] hist_q;

  // Synchroniser chain, all channels shifted in parallel
  always_ff @(posedge i_dst_clk or negedge i_dst_rstn) begin
    if (!i_dst_rstn) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_signal};
    end
  end

  assign sync_s = sync_q[STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_no_filter
    assign level = sync_s;
  end else begin : g_filter
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
      logic             filt_q;
      logic             filt_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Count consecutive disagreeing samples; accept on the last one
      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_s[ch] != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync_s[ch];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // Filter state; reset discards any count in progress
      always_ff @(posedge i_dst_clk or negedge i_dst_rstn) begin
        if (!i_dst_rstn) begin
          filt_q <= RST_VAL[ch];
          cnt_q  <= '0;
        end else begin
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign level[ch] = filt_q;
    end
  end

  // History of the output level; resets to RST_VAL so release shows no edge
  always_ff @(posedge i_dst_clk or negedge i_dst_rstn) begin
    if (!i_dst_rstn) begin
      hist_q <= RST_VAL;
    end else begin
      hist_q <= level;
    end
  end

  assign o_signal = level;
  assign o_rise   = level & ~hist_q;
  assign o_fall   = ~level & hist_q;
  assign o_change = |(o_rise | o_fall);

endmodule

// File: tb/tb_cdc_sync_bus.sv
// Bench for cdc_sync_bus: one unfiltered 8-channel instance and one filtered
// 4-channel instance, checked every cycle against a delay-line / run-length
// reference model, plus directed latency, glitch and reset scenarios.
module tb_cdc_sync_bus;

  localparam int unsigned AW = 8;
  localparam int unsigned AS = 3;
  localparam int unsigned AF = 0;
  localparam logic [AW-1:0] ARST = 8'h08;

  localparam int unsigned BW = 4;
  localparam int unsigned BS = 2;
  localparam int unsigned BF = 4;
  localparam logic [BW-1:0] BRST = 4'b1010;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ia, oa_sig, oa_rise, oa_fall;
  logic          oa_chg;
  logic [BW-1:0] ib, ob_sig, ob_rise, ob_fall;
  logic          ob_chg;

  cdc_sync_bus #(.WIDTH(AW), .STAGES(AS), .RST_VAL(ARST), .FILTER_CYCLES(AF)) u_dut_a (
    .i_dst_clk(clk), .i_dst_rstn(rst_n), .i_signal(ia),
    .o_signal(oa_sig), .o_rise(oa_rise), .o_fall(oa_fall), .o_change(oa_chg)
  );

  cdc_sync_bus #(.WIDTH(BW), .STAGES(BS), .RST_VAL(BRST), .FILTER_CYCLES(BF)) u_dut_b (
    .i_dst_clk(clk), .i_dst_rstn(rst_n), .i_signal(ib),
    .o_signal(ob_sig), .o_rise(ob_rise), .o_fall(ob_fall), .o_change(ob_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: delay line of input samples, then an N-sample agreement
  // window for the filtered instance, then edges from previous vs current level
  logic [AW-1:0] qa[$];
  logic [AW-1:0] ma_out, ma_prev;
  logic [BW-1:0] qb[$];
  logic [BW-1:0] sh[$];
  logic [BW-1:0] mb_out, mb_prev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      sh.delete();
      for (int i = 0; i < int'(AS); i++) qa.push_back(ARST);
      for (int i = 0; i < int'(BS); i++) qb.push_back(BRST);
      ma_out  = ARST;
      ma_prev = ARST;
      mb_out  = BRST;
      mb_prev = BRST;
    end else begin
      logic [BW-1:0] nxt;
      ma_prev = ma_out;
      qa.push_back(ia);
      void'(qa.pop_front());
      ma_out = qa[0];

      mb_prev = mb_out;
      sh.push_back(qb[0]);
      if (sh.size() > int'(BF)) void'(sh.pop_front());
      nxt = mb_out;
      if (sh.size() == int'(BF)) begin
        for (int b = 0; b < int'(BW); b++) begin
          logic agree;
          agree = 1'b1;
          for (int k = 0; k < int'(BF); k++) if (sh[k][b] == mb_out[b]) agree = 1'b0;
          if (agree) nxt[b] = ~mb_out[b];
        end
      end
      mb_out = nxt;
      qb.push_back(ib);
      void'(qb.pop_front());
    end
  end

  logic chk_en = 1'b0;

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [AW-1:0] ra, fa;
      logic [BW-1:0] rb, fb;
      ra = ma_out & ~ma_prev;
      fa = ~ma_out & ma_prev;
      rb = mb_out & ~mb_prev;
      fb = ~mb_out & mb_prev;
      check_eq("a_sig",  32'(oa_sig),  32'(ma_out));
      check_eq("a_rise", 32'(oa_rise), 32'(ra));
      check_eq("a_fall", 32'(oa_fall), 32'(fa));
      check_eq("a_chg",  32'(oa_chg),  32'(|(ra | fa)));
      check_eq("b_sig",  32'(ob_sig),  32'(mb_out));
      check_eq("b_rise", 32'(ob_rise), 32'(rb));
      check_eq("b_fall", 32'(ob_fall), 32'(fb));
      check_eq("b_chg",  32'(ob_chg),  32'(|(rb | fb)));
    end
  end

  int b2_rise, b2_fall, b0_rise, chg_cnt;
  logic b2_hi_seen;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      b2_rise    += int'(ob_rise[2]);
      b2_fall    += int'(ob_fall[2]);
      b0_rise    += int'(ob_rise[0]);
      chg_cnt    += int'(oa_chg) + int'(ob_chg);
      b2_hi_seen |= ob_sig[2];
    end
  endtask

  task automatic clr_cnt();
    b2_rise = 0; b2_fall = 0; b0_rise = 0; chg_cnt = 0; b2_hi_seen = 1'b0;
  endtask

  initial begin
    int lat;
    int hold_a, hold_b;
    rst_n = 1'b0;
    ia    = ARST;
    ib    = BRST;
    clr_cnt();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    step(1);
    rst_n = 1'b1;

    // Reset value held after release, no spurious pulses
    clr_cnt();
    step(10);
    check_eq("rst_b_sig", 32'(ob_sig), 32'(BRST));
    check_eq("rst_a_sig", 32'(oa_sig), 32'(ARST));
    check_eq("rst_pulses", 32'(chg_cnt), 32'd0);

    // Multi-channel: bits 0,5 rise while bit 3 falls, latency STAGES
    ia = 8'h21;
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      lat++;
      if (oa_sig == 8'h21) break;
    end
    check_eq("a_latency", 32'(lat), 32'(AS));
    check_eq("a_multi_rise", 32'(oa_rise), 32'h21);
    check_eq("a_multi_fall", 32'(oa_fall), 32'h08);
    check_eq("a_multi_chg", 32'(oa_chg), 32'd1);
    step(1);
    check_eq("a_chg_once", 32'(oa_chg), 32'd0);

    // Filter accept on bit 0: STAGES+FILTER cycles, single rise
    clr_cnt();
    ib[0] = 1'b1;
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      b0_rise += int'(ob_rise[0]);
      if (ob_sig[0]) break;
    end
    check_eq("b_accept_lat", 32'(lat), 32'(BS + BF));
    step(12);
    check_eq("b_accept_one_rise", 32'(b0_rise), 32'd1);
    ib[0] = 1'b0;
    step(12);

    // 3-cycle glitch is rejected
    clr_cnt();
    ib[2] = 1'b1;
    step(3);
    ib[2] = 1'b0;
    step(15);
    check_eq("glitch3_hi", 32'(b2_hi_seen), 32'd0);
    check_eq("glitch3_edges", 32'(b2_rise + b2_fall), 32'd0);

    // 4-cycle pulse passes as exactly one rise and one fall
    clr_cnt();
    ib[2] = 1'b1;
    step(4);
    ib[2] = 1'b0;
    step(15);
    check_eq("pulse4_hi", 32'(b2_hi_seen), 32'd1);
    check_eq("pulse4_rise", 32'(b2_rise), 32'd1);
    check_eq("pulse4_fall", 32'(b2_fall), 32'd1);
    check_eq("pulse4_end", 32'(ob_sig[2]), 32'd0);

    // Mid-operation reset two samples into an accepting transition
    ib[1] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_eq("mid_not_yet", 32'(ob_sig), 32'(BRST));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_b_sig", 32'(ob_sig), 32'(BRST));
    check_eq("mid_rst_a_sig", 32'(oa_sig), 32'(ARST));
    check_eq("mid_rst_pulses", 32'({ob_rise, ob_fall, oa_rise, oa_fall}), 32'd0);
    check_eq("mid_rst_chg", 32'({oa_chg, ob_chg}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (!ob_sig[1]) break;
    end
    check_eq("mid_rst_relat", 32'(lat), 32'(BS + BF));
    step(10);

    // Randomised level activity with random hold times
    hold_a = 0;
    hold_b = 0;
    repeat (3000) begin
      if (hold_a == 0) begin
        ia = 8'($urandom);
        hold_a = int'($urandom_range(1, 10));
      end
      if (hold_b == 0) begin
        ib = 4'($urandom);
        hold_b = int'($urandom_range(1, 9));
      end
      step(1);
      hold_a--;
      hold_b--;
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
